// File: rtl/csr_hpm.sv
// Machine counter CSR unit: mcycle, minstret, mhpmcounters, events, inhibit.
// One CSR access per two cycles; read-modify-write happens in the valid cycle.
module csr_hpm #(
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8,
  parameter int EVW        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rename_csr_write,
  input  logic [4:0]            rename_op,
  input  logic [6:0]            rename_robid,
  input  logic [5:0]            rename_rd,
  input  logic [31:0]           rename_op1,
  input  logic [31:0]           rename_imm,
  input  logic [NUM_EVENTS-1:0] hpm_event,
  output logic                  csr_valid,
  output logic                  csr_error,
  output logic [4:0]            csr_ecause,
  output logic [6:0]            csr_robid,
  output logic [5:0]            csr_rd,
  output logic [31:0]           csr_result,
  input  logic                  rob_flush,
  input  logic                  rob_ret_valid,
  input  logic [6:0]            rob_csr_head
);

  localparam int NC = NUM_HPM + 2;
  localparam logic [31:0] INH_MASK =
    32'h5 | 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);

  logic           valid_q;
  logic [1:0]     op_q;
  logic [11:0]    addr_q;
  logic [31:0]    op1_q;
  logic [6:0]     robid_q;
  logic [5:0]     rd_q;
  logic [63:0]    cnt_q [NC];
  logic [63:0]    cnt_d [NC];
  logic [31:0]    inh_q, inh_d;
  logic [EVW-1:0] evt_q [NUM_HPM];
  logic [EVW-1:0] evt_d [NUM_HPM];

  logic              accept, live, hi, shadow, ctr_space;
  logic              is_inh, hit, err, we;
  logic [NC-1:0]     ctr_oh, inc;
  logic [NUM_HPM-1:0] evt_oh;
  logic [31:0]       old, wdata;
  logic              unused_bits;

  assign unused_bits = ^{rename_op[4:2], rename_imm[31:12]};

  assign accept = rename_csr_write & ~valid_q & ~rob_flush;
  assign live   = valid_q & ~rob_flush;

  assign hi        = addr_q[7];
  assign shadow    = addr_q[11:8] == 4'hC;
  assign ctr_space = (addr_q[11:8] == 4'hB) | shadow;
  assign is_inh    = addr_q == 12'h320;

  function automatic logic ev_hit(
    input logic [EVW-1:0]        k,
    input logic [NUM_EVENTS-1:0] ev
  );
    logic h;
    h = 1'b0;
    for (int j = 1; j <= NUM_EVENTS; j++)
      if (k == EVW'(j)) h = h | ev[j-1];
    return h;
  endfunction

  // Address decode and pre-write read mux
  always_comb begin
    hit    = is_inh;
    ctr_oh = '0;
    evt_oh = '0;
    old    = is_inh ? inh_q : 32'h0;
    for (int c = 0; c < NC; c++) begin
      if (ctr_space &&
          addr_q[6:0] == 7'((c == 0) ? 0 : c + 1)) begin
        hit       = 1'b1;
        ctr_oh[c] = 1'b1;
        old = hi ? cnt_q[c][63:32] : cnt_q[c][31:0];
      end
    end
    for (int i = 0; i < NUM_HPM; i++) begin
      if (addr_q == 12'(12'h323 + i)) begin
        hit       = 1'b1;
        evt_oh[i] = 1'b1;
        old       = 32'(evt_q[i]);
      end
    end
  end

  assign err = ~hit | (op_q == 2'b00) |
               (shadow & ((op_q == 2'b01) | (op1_q != '0)));
  assign we  = live & ~err & ~shadow;

  always_comb begin
    case (op_q)
      2'b01:   wdata = op1_q;
      2'b10:   wdata = old | op1_q;
      2'b11:   wdata = old & ~op1_q;
      default: wdata = old;
    endcase
  end

  always_comb begin
    inc    = '0;
    inc[0] = ~inh_q[0];
    inc[1] = ~inh_q[2] & rob_ret_valid &
             (rob_csr_head != robid_q);
    for (int i = 0; i < NUM_HPM; i++)
      inc[i+2] = ~inh_q[i+3] & ev_hit(evt_q[i], hpm_event);
  end

  // A low-half write drops the increment entirely; a high-half
  // write keeps the low half's increment without its carry.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      cnt_d[c] = cnt_q[c] + 64'(inc[c]);
      if (we & ctr_oh[c]) begin
        if (hi)
          cnt_d[c] = {wdata, cnt_q[c][31:0] + 32'(inc[c])};
        else
          cnt_d[c] = {cnt_q[c][63:32], wdata};
      end
    end
    inh_d = (we & is_inh) ? (wdata & INH_MASK) : inh_q;
    for (int i = 0; i < NUM_HPM; i++)
      evt_d[i] = (we & evt_oh[i]) ? wdata[EVW-1:0] : evt_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      op1_q   <= '0;
      robid_q <= '0;
      rd_q    <= '0;
      inh_q   <= '0;
      for (int c = 0; c < NC; c++) cnt_q[c] <= '0;
      for (int i = 0; i < NUM_HPM; i++) evt_q[i] <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        op_q    <= rename_op[1:0];
        addr_q  <= rename_imm[11:0];
        op1_q   <= rename_op1;
        robid_q <= rename_robid;
        rd_q    <= rename_rd;
      end
      inh_q <= inh_d;
      for (int c = 0; c < NC; c++) cnt_q[c] <= cnt_d[c];
      for (int i = 0; i < NUM_HPM; i++) evt_q[i] <= evt_d[i];
    end
  end

  assign csr_valid  = live;
  assign csr_error  = live & err;
  assign csr_ecause = (live & err) ? 5'd2 : 5'd0;
  assign csr_result = (live & ~err) ? old : 32'h0;
  assign csr_robid  = robid_q;
  assign csr_rd     = rd_q;

endmodule

// File: tb/tb_csr_hpm.sv
// Scoreboard bench for csr_hpm: each access pushes its expected
// response; the observed response is captured in the valid cycle.
module tb_csr_hpm;

  localparam logic [1:0] RW = 2'b01;
  localparam logic [1:0] RS = 2'b10;
  localparam logic [1:0] RC = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rename_csr_write = 1'b0;
  logic [4:0]  rename_op = '0;
  logic [6:0]  rename_robid = '0;
  logic [5:0]  rename_rd = '0;
  logic [31:0] rename_op1 = '0;
  logic [31:0] rename_imm = '0;
  logic [7:0]  hpm_event = '0;
  logic        rob_flush = 1'b0;
  logic        rob_ret_valid = 1'b0;
  logic [6:0]  rob_csr_head = '0;
  logic        csr_valid, csr_error;
  logic [4:0]  csr_ecause;
  logic [6:0]  csr_robid;
  logic [5:0]  csr_rd;
  logic [31:0] csr_result;

  csr_hpm #(.NUM_HPM(4), .NUM_EVENTS(8), .EVW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rename_csr_write(rename_csr_write),
    .rename_op(rename_op), .rename_robid(rename_robid),
    .rename_rd(rename_rd), .rename_op1(rename_op1),
    .rename_imm(rename_imm), .hpm_event(hpm_event),
    .csr_valid(csr_valid), .csr_error(csr_error),
    .csr_ecause(csr_ecause), .csr_robid(csr_robid),
    .csr_rd(csr_rd), .csr_result(csr_result),
    .rob_flush(rob_flush), .rob_ret_valid(rob_ret_valid),
    .rob_csr_head(rob_csr_head)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [4:0]  c;
    logic [31:0] r;
    logic [6:0]  t;
    logic [5:0]  d;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  rsp_t ex, ob;
  int checks = 0;
  int errors = 0;
  logic [6:0] tag = '0;
  longint unsigned cyc = 0;
  longint unsigned samp_cyc = 0;
  longint unsigned ref_cyc = 0;

  // Edges since reset release: the value mcycle must hold when unwritten
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic rsp_t mk(input logic v, input logic e,
                              input logic [31:0] r,
                              input logic [6:0] t);
    rsp_t x;
    x.v = v;
    x.e = e;
    x.c = e ? 5'd2 : 5'd0;
    x.r = r;
    x.t = t;
    x.d = (t == 7'd0) ? 6'd0 : (t[5:0] ^ 6'h2A);
    return x;
  endfunction

  function automatic rsp_t cur();
    rsp_t x;
    x.v = csr_valid;
    x.e = csr_error;
    x.c = csr_ecause;
    x.r = csr_result;
    x.t = csr_robid;
    x.d = csr_rd;
    return x;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the valid cycle.
  task automatic csr_op(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] d, input logic fa,
                        input logic fv);
    tag = tag + 7'd1;
    rename_csr_write = 1'b1;
    rename_op = {3'b000, op};
    rename_robid = tag;
    rename_rd = tag[5:0] ^ 6'h2A;
    rename_op1 = d;
    rename_imm = {20'h0, a};
    rob_flush = fa;
    @(posedge clk);
    #1;
    rename_csr_write = 1'b0;
    rob_flush = fv;
    #1;
    obs_q.push_back(cur());
    samp_cyc = cyc;
    @(posedge clk);
    #1;
    rob_flush = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] ev, input int n);
    repeat (n) begin
      hpm_event = ev;
      @(posedge clk);
      #1;
      hpm_event = '0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [6:0] head);
    rob_ret_valid = 1'b1;
    rob_csr_head = head;
    @(posedge clk);
    #1;
    rob_ret_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    exp_q.push_back(mk(0, 0, 0, 0));
    obs_q.push_back(cur());
    rename_csr_write = 1'b1;
    rename_robid = 7'h55;
    rename_rd = 6'h11;
    rename_imm = 32'hB00;
    rename_op = 5'd2;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    obs_q.push_back(cur());
    rename_csr_write = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL reset: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_mcycle_read();
    idle(9);
    csr_op(RS, 12'hC00, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd10, tag));
    csr_op(RS, 12'hC02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RC, 12'hC83, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'h320, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'h323, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL mcycle_read: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_carry();
    csr_op(RW, 12'hB80, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RW, 12'hB00, 32'hFFFF_FFFF, 0, 0);
    exp_q.push_back(mk(1, 0, samp_cyc[31:0], tag));
    ref_cyc = samp_cyc + 1;
    idle(1);
    csr_op(RS, 12'hB80, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 1, tag));
    csr_op(RS, 12'hC80, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 1, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL carry: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_errors();
    csr_op(RW, 12'hB00, 32'd100, 0, 0);
    exp_q.push_back(mk(1, 0,
      32'(64'hFFFF_FFFF + (samp_cyc - ref_cyc)), tag));
    csr_op(RW, 12'hC00, 32'd1, 0, 0);
    exp_q.push_back(mk(1, 1, 0, tag));
    csr_op(RS, 12'hB00, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd103, tag));
    csr_op(RW, 12'hB07, 32'd5, 0, 0);
    exp_q.push_back(mk(1, 1, 0, tag));
    csr_op(RS, 12'hC00, 32'd1, 0, 0);
    exp_q.push_back(mk(1, 1, 0, tag));
    csr_op(2'b00, 12'hB00, 32'hFFFF, 0, 0);
    exp_q.push_back(mk(1, 1, 0, tag));
    csr_op(RS, 12'hB01, 0, 0, 0);
    exp_q.push_back(mk(1, 1, 0, tag));
    csr_op(RS, 12'h327, 0, 0, 0);
    exp_q.push_back(mk(1, 1, 0, tag));
    csr_op(RC, 12'hC02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL errors: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_hpm();
    csr_op(RW, 12'h323, 32'h302, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'h323, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 2, tag));
    pulse(8'h02, 5);
    pulse(8'h01, 3);
    csr_op(RS, 12'hB03, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 5, tag));
    csr_op(RS, 12'hC03, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 5, tag));
    csr_op(RS, 12'hB83, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'h320, 32'h8, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    pulse(8'h02, 4);
    csr_op(RW, 12'h324, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RW, 12'h325, 32'd9, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RW, 12'h326, 32'd8, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    pulse(8'hFF, 3);
    csr_op(RS, 12'hB03, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 5, tag));
    csr_op(RS, 12'hB04, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'hB05, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'hB06, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 3, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL hpm: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_inhibit_mask();
    csr_op(RW, 12'h320, 32'hFFFF_FFFF, 0, 0);
    exp_q.push_back(mk(1, 0, 32'h8, tag));
    csr_op(RS, 12'h320, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'h7D, tag));
    csr_op(RW, 12'h320, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'h7D, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL inhibit: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] t1;
    tag = tag + 7'd1;
    t1 = tag;
    rename_csr_write = 1'b1;
    rename_op = {3'b000, RS};
    rename_robid = t1;
    rename_rd = t1[5:0] ^ 6'h2A;
    rename_op1 = '0;
    rename_imm = 32'hB02;
    @(posedge clk);
    #1;
    rename_robid = t1 + 7'd1;
    rename_rd = 6'h3F;
    #1;
    obs_q.push_back(cur());
    exp_q.push_back(mk(1, 0, 0, t1));
    @(posedge clk);
    #1;
    rename_csr_write = 1'b0;
    #1;
    obs_q.push_back(cur());
    exp_q.push_back(mk(0, 0, 0, t1));
    @(posedge clk);
    #1;
    csr_op(RW, 12'hB02, 32'd7, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RW, 12'hB02, 32'd99, 0, 1);
    exp_q.push_back(mk(0, 0, 0, tag));
    csr_op(RW, 12'hB02, 32'd55, 1, 0);
    exp_q.push_back(mk(0, 0, 0, tag - 7'd1));
    csr_op(RS, 12'hB02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd7, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL back_to_back: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_retire();
    retire(tag);
    retire(tag + 7'd1);
    csr_op(RS, 12'hB02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd8, tag));
    rob_ret_valid = 1'b1;
    rob_csr_head = tag + 7'd64;
    csr_op(RW, 12'hB02, 32'd50, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd9, tag));
    rob_ret_valid = 1'b0;
    csr_op(RS, 12'hB02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd50, tag));
    csr_op(RW, 12'hB82, 32'hFFFF_FFFF, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RW, 12'hB02, 32'hFFFF_FFFF, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd50, tag));
    retire(tag + 7'd64);
    csr_op(RS, 12'hB02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'hB82, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    rob_ret_valid = 1'b1;
    rob_csr_head = tag + 7'd64;
    csr_op(RW, 12'hB82, 32'd3, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    rob_ret_valid = 1'b0;
    csr_op(RS, 12'hB02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd2, tag));
    csr_op(RS, 12'hC82, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd3, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL retire: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_async_reset();
    tag = tag + 7'd1;
    rename_csr_write = 1'b1;
    rename_op = {3'b000, RW};
    rename_robid = tag;
    rename_rd = tag[5:0] ^ 6'h2A;
    rename_op1 = 32'h1234;
    rename_imm = 32'hB02;
    @(posedge clk);
    #1;
    rename_csr_write = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    obs_q.push_back(cur());
    exp_q.push_back(mk(0, 0, 0, 0));
    tag = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    csr_op(RS, 12'hB00, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 32'd1, tag));
    csr_op(RS, 12'hB02, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'hB82, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'h320, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'h323, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    csr_op(RS, 12'hB06, 0, 0, 0);
    exp_q.push_back(mk(1, 0, 0, tag));
    while (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ob = obs_q.pop_front();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL async_reset: got %h want %h", ob, ex);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mcycle_read();
    test_carry();
    test_errors();
    test_hpm();
    test_inhibit_mask();
    test_back_to_back();
    test_retire();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
